// File: rtl/text_value_formatter.sv
// text_value_formatter: turns an unsigned binary value into a right-aligned
// decimal ASCII field inside a character buffer using a one-bit-per-clock
// double-dabble. The result is handed to the overlay with a
// wr_ready / wr_completed handshake. Static label characters can be written
// into the buffer while idle.
//
//  state     | meaning
//  ----------+------------------------------------------------------------
//  IDLE      | accepts i_start (wins) or a label write
//  CONVERT   | VALUE_WIDTH double-dabble shift steps, sticky overflow
//  FORMAT    | NUM_DIGITS cycles, one field character per cycle, MSD first
//  HANDOFF   | o_wr_ready high until overlay reports it is writing
//  WAIT_DONE | wait for overlay idle again, then pulse o_done
module text_value_formatter #(
  parameter int NUM_CHAR      = 16,
  parameter int VALUE_WIDTH   = 16,
  parameter int NUM_DIGITS    = 5,
  parameter int DIGIT_POS     = 11,
  parameter int LEADING_BLANK = 1
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_start,
  input  logic [VALUE_WIDTH-1:0]        i_value,
  input  logic                          i_lbl_we,
  input  logic [$clog2(NUM_CHAR)-1:0]   i_lbl_addr,
  input  logic [7:0]                    i_lbl_char,
  input  logic                          i_wr_completed,
  output logic [NUM_CHAR-1:0][7:0]      o_characters,
  output logic                          o_wr_ready,
  output logic                          o_busy,
  output logic                          o_done
);

  localparam int AW         = $clog2(NUM_CHAR);
  localparam int BCD_W      = 4 * NUM_DIGITS;
  localparam int CNT_MAX    = (VALUE_WIDTH > NUM_DIGITS) ? VALUE_WIDTH : NUM_DIGITS;
  localparam int CNT_W      = $clog2(CNT_MAX + 1);
  // Element index of the field's least-significant digit; the digit written
  // while the down-counter reads c lands at FIELD_BASE + c.
  localparam int FIELD_BASE = NUM_CHAR - DIGIT_POS - NUM_DIGITS;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CONVERT,
    S_FORMAT,
    S_HANDOFF,
    S_WAIT_DONE
  } state_t;

  state_t                     state_q;
  logic [VALUE_WIDTH-1:0]     value_q;
  logic [BCD_W-1:0]           bcd_q;
  logic [BCD_W-1:0]           bcd_adj_d;
  logic                       ovf_q;
  logic                       nz_seen_q;
  logic [CNT_W-1:0]           cnt_q;
  logic [NUM_CHAR-1:0][7:0]   chars_q;
  logic                       wr_ready_q;
  logic                       done_q;

  logic [3:0]                 digit_d;
  logic [7:0]                 fmt_char_d;
  logic [AW-1:0]              fld_idx_d;
  logic [AW-1:0]              lbl_idx_d;
  logic                       lbl_ok_d;

  // Add-3 correction of every BCD digit that is 5 or more, ahead of the shift.
  always_comb begin
    bcd_adj_d = bcd_q;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj_d[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
  end

  // Character chosen for the digit currently at the top of the BCD register.
  always_comb begin
    digit_d   = bcd_q[BCD_W-1 -: 4];
    fld_idx_d = AW'(FIELD_BASE) + AW'(cnt_q);
    lbl_idx_d = AW'(NUM_CHAR - 1) - i_lbl_addr;
    lbl_ok_d  = ({1'b0, i_lbl_addr} < (AW + 1)'(NUM_CHAR));
    if (ovf_q) begin
      fmt_char_d = 8'h2D;
    end else if ((LEADING_BLANK != 0) && !nz_seen_q && (digit_d == 4'd0) && (cnt_q != '0)) begin
      fmt_char_d = 8'h20;
    end else begin
      fmt_char_d = {4'h3, digit_d};
    end
  end

  // Sequencer FSM with all datapath registers and registered outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= S_IDLE;
      value_q    <= '0;
      bcd_q      <= '0;
      ovf_q      <= 1'b0;
      nz_seen_q  <= 1'b0;
      cnt_q      <= '0;
      chars_q    <= {NUM_CHAR{8'h20}};
      wr_ready_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (i_start) begin
            value_q   <= i_value;
            bcd_q     <= '0;
            ovf_q     <= 1'b0;
            nz_seen_q <= 1'b0;
            cnt_q     <= CNT_W'(VALUE_WIDTH - 1);
            state_q   <= S_CONVERT;
          end else if (i_lbl_we && lbl_ok_d) begin
            chars_q[lbl_idx_d] <= i_lbl_char;
          end
        end
        S_CONVERT: begin
          bcd_q   <= {bcd_adj_d[BCD_W-2:0], value_q[VALUE_WIDTH-1]};
          value_q <= {value_q[VALUE_WIDTH-2:0], 1'b0};
          ovf_q   <= ovf_q | bcd_adj_d[BCD_W-1];
          if (cnt_q == '0) begin
            cnt_q   <= CNT_W'(NUM_DIGITS - 1);
            state_q <= S_FORMAT;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_FORMAT: begin
          chars_q[fld_idx_d] <= fmt_char_d;
          bcd_q              <= bcd_q << 4;
          if (digit_d != 4'd0) begin
            nz_seen_q <= 1'b1;
          end
          if (cnt_q == '0) begin
            state_q <= S_HANDOFF;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_HANDOFF: begin
          // Ready is raised on the first HANDOFF cycle; the overlay going
          // busy is only honoured once the request is actually visible.
          if (wr_ready_q && !i_wr_completed) begin
            wr_ready_q <= 1'b0;
            state_q    <= S_WAIT_DONE;
          end else begin
            wr_ready_q <= 1'b1;
          end
        end
        S_WAIT_DONE: begin
          if (i_wr_completed) begin
            done_q  <= 1'b1;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_characters = chars_q;
  assign o_wr_ready   = wr_ready_q;
  assign o_busy       = (state_q != S_IDLE);
  assign o_done       = done_q;

endmodule

// File: tb/tb_text_value_formatter.sv
// Directed bench for text_value_formatter: default instance plus a
// LEADING_BLANK=0 instance and a 4-digit instance sharing the same stimulus.
module tb_text_value_formatter;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               start = 1'b0;
  logic [15:0]        value = '0;
  logic               lbl_we = 1'b0;
  logic [3:0]         lbl_addr = '0;
  logic [7:0]         lbl_char = '0;
  logic               wr_completed = 1'b1;

  logic [15:0][7:0]   ch0, ch1, ch2;
  logic               ready0, ready1, ready2;
  logic               busy0, busy1, busy2;
  logic               done0, done1, done2;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  text_value_formatter dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_value(value),
    .i_lbl_we(lbl_we), .i_lbl_addr(lbl_addr), .i_lbl_char(lbl_char),
    .i_wr_completed(wr_completed), .o_characters(ch0), .o_wr_ready(ready0),
    .o_busy(busy0), .o_done(done0)
  );

  text_value_formatter #(.LEADING_BLANK(0)) dut_lb0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_value(value),
    .i_lbl_we(lbl_we), .i_lbl_addr(lbl_addr), .i_lbl_char(lbl_char),
    .i_wr_completed(wr_completed), .o_characters(ch1), .o_wr_ready(ready1),
    .o_busy(busy1), .o_done(done1)
  );

  text_value_formatter #(.NUM_DIGITS(4), .DIGIT_POS(12)) dut_d4 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_value(value),
    .i_lbl_we(lbl_we), .i_lbl_addr(lbl_addr), .i_lbl_char(lbl_char),
    .i_wr_completed(wr_completed), .o_characters(ch2), .o_wr_ready(ready2),
    .o_busy(busy2), .o_done(done2)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // poke: inject start/label during CONVERT; simul: label write together with start.
  task automatic do_conv(input logic [15:0] v, input bit poke, input bit simul);
    int n;
    int dones;
    @(negedge clk);
    start = 1'b1;
    value = v;
    if (simul) begin
      lbl_we = 1'b1; lbl_addr = 4'd2; lbl_char = "Q";
    end
    @(posedge clk); #1;
    start = 1'b0;
    lbl_we = 1'b0;
    check("busy_after_start", busy0, 1'b1);
    n = 0;
    while (n < 60) begin
      if (poke && n == 3) begin
        start = 1'b1; value = 16'd999;
        lbl_we = 1'b1; lbl_addr = 4'd1; lbl_char = "X";
      end else begin
        start = 1'b0; lbl_we = 1'b0;
      end
      @(posedge clk); #1;
      n++;
      if (ready0) break;
    end
    start = 1'b0; lbl_we = 1'b0;
    check("ready_latency", n, 22);
    repeat (2) @(posedge clk);
    #1 wr_completed = 1'b0;
    check("ready_held", ready0, 1'b1);
    @(posedge clk); #1;
    check("ready_drop", ready0, 1'b0);
    repeat (15) @(posedge clk);
    #1 wr_completed = 1'b1;
    dones = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (done0) dones++;
    end
    check("done_once", dones, 1);
    check("all_idle", {busy0, busy1, busy2}, 3'b000);
  endtask

  initial begin
    // reset
    #12;
    check("rst_chars", ch0, {16{8'h20}});
    check("rst_ready", ready0, 1'b0);
    check("rst_busy", busy0, 1'b0);
    check("rst_done", done0, 1'b0);
    @(negedge clk) rst_n = 1'b1;

    // label write in IDLE
    @(negedge clk);
    lbl_we = 1'b1; lbl_addr = 4'd0; lbl_char = "T";
    @(negedge clk) lbl_we = 1'b0;
    check("label_T", ch0[15], 8'h54);

    // 1234
    do_conv(16'd1234, 1'b0, 1'b0);
    check("f1234", ch0[4:0], {8'h20, "1234"});
    check("f1234_lb0", ch1[4:0], "01234");
    check("f1234_d4", ch2[3:0], "1234");
    check("label_kept", ch0[15], 8'h54);
    check("outside_untouched", ch0[14:5], {10{8'h20}});

    // 0
    do_conv(16'd0, 1'b0, 1'b0);
    check("f0", ch0[4:0], {32'h20202020, "0"});
    check("f0_lb0", ch1[4:0], "00000");
    check("f0_d4", ch2[3:0], {24'h202020, "0"});

    // 65535
    do_conv(16'hFFFF, 1'b0, 1'b0);
    check("fmax", ch0[4:0], "65535");
    check("fmax_lb0", ch1[4:0], "65535");
    check("fmax_d4_ovf", ch2[3:0], "----");

    // label inside field, then conversion with inputs poked while busy
    @(negedge clk);
    lbl_we = 1'b1; lbl_addr = 4'd13; lbl_char = "#";
    @(negedge clk) lbl_we = 1'b0;
    check("label_in_field", ch0[2], 8'h23);
    do_conv(16'd321, 1'b1, 1'b0);
    check("f321_busy_ignored", ch0[4:0], {16'h2020, "321"});
    check("busy_label_dropped", ch0[14], 8'h20);

    // simultaneous start and label write
    do_conv(16'd7, 1'b0, 1'b1);
    check("f7", ch0[4:0], {32'h20202020, "7"});
    check("simul_label_dropped", ch0[13], 8'h20);

    // reset in the middle of CONVERT
    @(negedge clk);
    start = 1'b1; value = 16'd500;
    @(negedge clk) start = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_chars", ch0, {16{8'h20}});
    check("mid_rst_ready", ready0, 1'b0);
    check("mid_rst_busy", busy0, 1'b0);
    @(negedge clk) rst_n = 1'b1;
    do_conv(16'd42, 1'b0, 1'b0);
    check("f42", ch0[4:0], {24'h202020, "42"});

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
